// File: rtl/amo_controller_pkg.sv
// amo_controller_pkg: shared definitions for the RV32A atomic sequencer.
//   - funct5 codes of the RV32A instructions plus ATOMIC_NO_OP (outside
//     the RV32A code space, means "no atomic request")
//   - 3-bit FSM state encoding
//   - MEM_WORD (bytes per memory word) and the derived word-offset width
//   - is_atomic_op(): true for every funct5 code this unit executes
package amo_controller_pkg;

  localparam logic [4:0] ATOMIC_ADD   = 5'b00000;
  localparam logic [4:0] ATOMIC_SWAP  = 5'b00001;
  localparam logic [4:0] ATOMIC_LR    = 5'b00010;
  localparam logic [4:0] ATOMIC_SC    = 5'b00011;
  localparam logic [4:0] ATOMIC_XOR   = 5'b00100;
  localparam logic [4:0] ATOMIC_OR    = 5'b01000;
  localparam logic [4:0] ATOMIC_AND   = 5'b01100;
  localparam logic [4:0] ATOMIC_MIN   = 5'b10000;
  localparam logic [4:0] ATOMIC_MAX   = 5'b10100;
  localparam logic [4:0] ATOMIC_MINU  = 5'b11000;
  localparam logic [4:0] ATOMIC_MAXU  = 5'b11100;
  localparam logic [4:0] ATOMIC_NO_OP = 5'b11111;

  // Bytes per memory word; the low WORD_LSB address bits select a byte.
  localparam int MEM_WORD = 4;
  localparam int WORD_LSB = $clog2(MEM_WORD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_MODIFY = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } amo_state_e;

  function automatic logic is_atomic_op(input logic [4:0] op);
    logic known;
    known = 1'b0;
    case (op)
      ATOMIC_ADD, ATOMIC_SWAP, ATOMIC_LR, ATOMIC_SC, ATOMIC_XOR,
      ATOMIC_OR, ATOMIC_AND, ATOMIC_MIN, ATOMIC_MAX, ATOMIC_MINU,
      ATOMIC_MAXU: known = 1'b1;
      default:     known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/amo_controller_alu.sv
// amo_alu: combinational read-modify-write function of the AMO instructions.
//   atomic_op  in  5     funct5 code of the latched request
//   old        in  XLEN  value read from memory
//   operand    in  XLEN  rs2 value
//   new_value  out XLEN  value to write back
// MIN/MAX compare signed, MINU/MAXU unsigned; on a tie the old value is kept.
// Codes without a modify step (LR/SC/unknown) pass the old value through.
module amo_alu
  import amo_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      atomic_op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] new_value
);

  logic signed [XLEN-1:0] old_s;
  logic signed [XLEN-1:0] operand_s;
  logic                   lt_signed;
  logic                   gt_signed;
  logic                   lt_unsigned;
  logic                   gt_unsigned;

  assign old_s       = old;
  assign operand_s   = operand;
  // Strict comparisons of operand against old so ties select old.
  assign lt_signed   = operand_s < old_s;
  assign gt_signed   = operand_s > old_s;
  assign lt_unsigned = operand < old;
  assign gt_unsigned = operand > old;

  always_comb begin
    new_value = old;
    case (atomic_op)
      ATOMIC_SWAP: new_value = operand;
      ATOMIC_ADD:  new_value = old + operand;
      ATOMIC_XOR:  new_value = old ^ operand;
      ATOMIC_AND:  new_value = old & operand;
      ATOMIC_OR:   new_value = old | operand;
      ATOMIC_MIN:  new_value = lt_signed   ? operand : old;
      ATOMIC_MAX:  new_value = gt_signed   ? operand : old;
      ATOMIC_MINU: new_value = lt_unsigned ? operand : old;
      ATOMIC_MAXU: new_value = gt_unsigned ? operand : old;
      default:     new_value = old;
    endcase
  end

endmodule

// File: rtl/amo_controller.sv
// amo_controller: multi-cycle sequencer for RV32A atomics.
//   clk, reset          clock, synchronous active-high reset
//   start, atomic_op,   request strobe (sampled in IDLE only), funct5 code,
//   address, operand    rs1 address and rs2 operand
//   busy                high while a request is in flight (through DONE)
//   done                one-cycle completion pulse; result/misaligned valid
//   result              rd value, held until the next done
//   misaligned          with done: address not word aligned, no access made
//   mem_*               data-memory port; strobes held until mem_ready
//   snoop_write/_addr   store by another master, breaks a matching reservation
//   reservation_valid   LR/SC reservation currently held
// Flow: IDLE -> READ -> MODIFY -> WRITE -> DONE for AMOs, IDLE -> READ -> DONE
// for LR, IDLE -> WRITE -> DONE (or straight to DONE on failure) for SC.
module amo_controller
  import amo_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      atomic_op,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] operand,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            misaligned,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  input  logic            snoop_write,
  input  logic [XLEN-1:0] snoop_addr,
  output logic            reservation_valid
);

  localparam int WORD_W = XLEN - WORD_LSB;

  amo_state_e        state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              mis_q, mis_d;
  logic              res_valid_q, res_valid_d;
  logic [WORD_W-1:0] res_word_q, res_word_d;

  logic [XLEN-1:0]   alu_new;
  logic [WORD_W-1:0] req_word;
  logic [WORD_W-1:0] snoop_word;
  logic              req_misaligned;
  logic              snoop_hits_held;
  logic              unused_snoop_lsb;

  assign req_word         = address[XLEN-1:WORD_LSB];
  assign snoop_word       = snoop_addr[XLEN-1:WORD_LSB];
  assign req_misaligned   = address[WORD_LSB-1:0] != '0;
  assign snoop_hits_held  = snoop_write && (snoop_word == res_word_q);
  // Snoops are word granular; the byte offset carries no information.
  assign unused_snoop_lsb = ^snoop_addr[WORD_LSB-1:0];

  amo_alu #(.XLEN(XLEN)) u_amo_alu (
    .atomic_op (op_q),
    .old       (old_q),
    .operand   (operand_q),
    .new_value (alu_new)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    operand_d   = operand_q;
    old_d       = old_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    mis_d       = mis_q;
    res_valid_d = res_valid_q;
    res_word_d  = res_word_q;

    case (state_q)
      ST_IDLE: begin
        if (start && is_atomic_op(atomic_op)) begin
          op_d      = atomic_op;
          word_d    = req_word;
          operand_d = operand;
          mis_d     = req_misaligned;
          if (req_misaligned) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else if (atomic_op == ATOMIC_SC) begin
            // Every SC consumes the reservation, success or not. A snoop
            // landing in this very cycle already counts against it.
            res_valid_d = 1'b0;
            if (res_valid_q && (res_word_q == req_word) && !snoop_hits_held) begin
              wdata_d = operand;
              state_d = ST_WRITE;
            end else begin
              result_d = {{(XLEN-1){1'b0}}, 1'b1};
              state_d  = ST_DONE;
            end
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (mem_ready) begin
          old_d = mem_rdata;
          if (op_q == ATOMIC_LR) begin
            result_d    = mem_rdata;
            res_valid_d = 1'b1;
            res_word_d  = word_q;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_MODIFY;
          end
        end
      end

      ST_MODIFY: begin
        wdata_d = alu_new;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        if (mem_ready) begin
          if (op_q == ATOMIC_SC) begin
            result_d = '0;
          end else begin
            result_d = old_q;
            // Our own AMO store to the reserved word breaks the reservation.
            if (res_word_q == word_q) begin
              res_valid_d = 1'b0;
            end
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Compared against the next reservation word so a snoop coinciding with
    // an LR completion to the same word leaves the reservation cleared.
    if (snoop_write && (snoop_word == res_word_d)) begin
      res_valid_d = 1'b0;
    end
  end

  // Control and every register visible on an output port reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mis_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_word_q  <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mis_q       <= mis_d;
      res_valid_q <= res_valid_d;
      res_word_q  <= res_word_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
    end
  end

  // Request datapath: only read after being loaded on acceptance.
  always_ff @(posedge clk) begin
    op_q      <= op_d;
    operand_q <= operand_d;
    old_q     <= old_d;
  end

  assign busy              = state_q != ST_IDLE;
  assign done              = state_q == ST_DONE;
  assign misaligned        = done && mis_q;
  assign result            = result_q;
  assign mem_read          = state_q == ST_READ;
  assign mem_write         = state_q == ST_WRITE;
  assign mem_addr          = {word_q, {WORD_LSB{1'b0}}};
  assign mem_wdata         = wdata_q;
  assign reservation_valid = res_valid_q;

endmodule
